// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        WAIT_TILL_EMPTY    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    localparam logic [1:0] ILLEGAL_ADDR = 2'b11;
    localparam int         DROP_CNT_W   = 8;

    function automatic logic addr_legal(input logic [1:0] addr);
        return addr != ILLEGAL_ADDR;
    endfunction

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing controller: header decode, payload/parity load, full stall, soft-reset abort.
// Optional aborted-packet counter enabled by defining ROUTER_FSM_DROP_CNT_EN.
module router_fsm
    import router_pkg::*;
(
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [1:0]            data_in,
    input  logic                  fifo_full,
    input  logic                  fifo_empty_0,
    input  logic                  fifo_empty_1,
    input  logic                  fifo_empty_2,
    input  logic                  soft_reset_0,
    input  logic                  soft_reset_1,
    input  logic                  soft_reset_2,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic                  busy,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  write_enb_reg,
    output logic                  rst_int_reg,
    output logic [DROP_CNT_W-1:0] pkt_drop_cnt
);

    state_t     state_reg, state_next;
    logic [1:0] addr_reg, addr_next;
    logic [3:0] fifo_empty_vec;
    logic [3:0] soft_reset_vec;
    logic       header_ok;
    logic       abort;

    // Slot 3 is padding so the illegal address indexes a defined 0.
    assign fifo_empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset_vec = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};

    assign header_ok = (state_reg == DECODE_ADDRESS) && pkt_valid && addr_legal(data_in);
    assign abort     = (state_reg != DECODE_ADDRESS) && soft_reset_vec[addr_reg];
    assign addr_next = header_ok ? data_in : addr_reg;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_reg <= DECODE_ADDRESS;
            addr_reg  <= 2'd0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = DECODE_ADDRESS;
        end else begin
            case (state_reg)
                DECODE_ADDRESS: begin
                    if (header_ok)
                        state_next = fifo_empty_vec[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
                WAIT_TILL_EMPTY: begin
                    if (fifo_empty_vec[addr_reg])
                        state_next = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: state_next = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full)
                        state_next = FIFO_FULL_STATE;
                    else if (!pkt_valid)
                        state_next = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full)
                        state_next = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)
                        state_next = DECODE_ADDRESS;
                    else if (low_pkt_valid)
                        state_next = LOAD_PARITY;
                    else
                        state_next = LOAD_DATA;
                end
                LOAD_PARITY: state_next = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    state_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: state_next = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore decodes only; nothing here looks at inputs.
    always_comb begin
        detect_add    = (state_reg == DECODE_ADDRESS);
        lfd_state     = (state_reg == LOAD_FIRST_DATA);
        ld_state      = (state_reg == LOAD_DATA);
        laf_state     = (state_reg == LOAD_AFTER_FULL);
        full_state    = (state_reg == FIFO_FULL_STATE);
        write_enb_reg = (state_reg == LOAD_DATA) || (state_reg == LOAD_AFTER_FULL) ||
                        (state_reg == LOAD_PARITY);
        rst_int_reg   = (state_reg == CHECK_PARITY_ERROR);
        busy          = !((state_reg == DECODE_ADDRESS) || (state_reg == LOAD_DATA));
    end

`ifdef ROUTER_FSM_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_cnt_reg;

    always_ff @(posedge clock) begin
        if (!resetn)
            drop_cnt_reg <= '0;
        else if (abort && (drop_cnt_reg != {DROP_CNT_W{1'b1}}))
            drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end

    assign pkt_drop_cnt = drop_cnt_reg;
`else
    assign pkt_drop_cnt = '0;
`endif

endmodule
